relu_argmax_classifier: RTL and testbench
=========================================

Name: relu_argmax_classifier

Overview:
- Downstream consumer of the final neuron layer: takes the 10 ReLU-clamped IEEE-754 single-precision node outputs in one parallel word.
- Scans them one lane per cycle and reports the winning class index and its value over a valid/ready handshake.
- Registers the combinational neuron network's outputs and is the classification decision point for the ECG pipeline.

Parameters:
- NUM_IN, 10, number of neuron outputs (classes) scanned; legal range 2..16.
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= NUM_IN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid activation vector.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- in_data  input  32*NUM_IN  lane i at bits [32*i+31 : 32*i], float32.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_class  output  IDX_W  index of the maximum lane.
- out_max  output  32  float32 value of the winning lane, after sanitising.
- out_all_zero  output  1  every sanitised lane was +0 (no neuron fired).
- out_neg_seen  output  1  at least one raw lane had bit 31 set; diagnostic only.

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1 after release; out_valid=0, out_class=0, out_max=0, out_all_zero=0, out_neg_seen=0; lane buffer and scan counter cleared. Reset mid-SCAN or mid-DONE aborts immediately; the partial result is discarded and never presented.
- Sanitising: any lane with bit 31 = 1 is replaced by 32'h00000000 before comparison, mirroring the upstream ReLU. The raw sign bits are ORed into out_neg_seen.
- Compare: sanitised lanes are non-negative, so they are compared as 32-bit unsigned integers with no FP unit.
  - +Inf (7F800000) beats every finite value.
  - NaN patterns above 7F800000 beat +Inf, unsigned-ordered. NaN is not otherwise special-cased.
- Ties: strictly-greater replaces, so the lowest index wins.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - capture all lanes into the buffer;
    - best_val <= sanitised lane 0; best_idx <= 0; scan index i <= 1;
    - neg flag <= raw lane 0 bit 31;
    - go to SCAN.
  - SCAN: each cycle compare lane i with best_val and update best_val/best_idx if greater; accumulate the neg flag; i <= i+1. When i = NUM_IN-1 is processed, go to DONE. in_ready=0; in_data is ignored.
  - DONE: out_valid=1. Outputs are driven from registers and held stable while out_ready=0, for an unbounded stall. On out_valid&out_ready, go to IDLE: out_valid drops on the next edge and in_ready rises on the same edge.
- Latency:
  - accept edge at cycle k;
  - NUM_IN-1 scan edges follow;
  - out_valid is high after edge k+NUM_IN-1 (k+9 for the default);
  - minimum accept-to-accept throughput is NUM_IN+1 cycles.
- out_all_zero = (best_val == 0). It is registered and valid whenever out_valid=1.
- Outputs other than out_valid are don't-care-stable when out_valid=0, but must keep their last values: no glitching to X.
- in_valid asserted during SCAN/DONE is not accepted and not lost by the block. The upstream holds it until in_ready.

Test Plan:
- Reset release, lanes = {0.5,2.0,1.0,0,…}, i.e. lane0=3F000000, lane1=40000000, lane2=3F800000, others 0: out_valid at k+9; out_class=1, out_max=40000000, out_all_zero=0, out_neg_seen=0.
- Tie: lanes 3 and 7 = 3F800000, all others 0: out_class=3, out_max=3F800000.
- All lanes 0, lane 5 = BF800000 (-1.0): out_class=0, out_max=0, out_all_zero=1, out_neg_seen=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Outputs stay constant, in_ready=0, and a second in_valid is not accepted. Release out_ready: one handshake, then in_ready=1 the next cycle and the second vector is accepted.
- Lane 9 = 7F800000 (+Inf), lane 0 = 7F7FFFFF: out_class=9. Confirms the last lane is scanned.
- Assert rst_n=0 at scan cycle 4, release after 2 cycles: out_valid never rises for the aborted vector, all outputs are 0, and the next vector classifies correctly.

Source files
------------

// File: rtl/relu_argmax_classifier.sv
// relu_argmax_classifier
//   Final decision stage of the ECG pipeline. Accepts NUM_IN float32 neuron
//   outputs in one parallel word. Negative lanes are clamped to +0, as the
//   upstream ReLU does. The lanes are then scanned one per cycle to find the
//   largest one. The winning class index and its value are presented over a
//   valid/ready handshake.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_in_valid      i_in_data holds a valid activation vector
//   o_in_ready      block can accept a vector (high only while idle)
//   i_in_data       lane i at bits [32*i+31 : 32*i], float32
//   o_out_valid     result available
//   i_out_ready     consumer accepts result
//   o_out_class     index of the maximum lane
//   o_out_max       sanitised float32 value of the winning lane
//   o_out_all_zero  every sanitised lane was +0
//   o_out_neg_seen  at least one raw lane had its sign bit set (diagnostic)
module relu_argmax_classifier #(
  parameter int unsigned NUM_IN = 10,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [32*NUM_IN-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [IDX_W-1:0]     o_out_class,
  output logic [31:0]          o_out_max,
  output logic                 o_out_all_zero,
  output logic                 o_out_neg_seen
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_IN - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;

  logic [32*NUM_IN-1:0]  r_buf;
  logic [IDX_W-1:0]      r_scan;
  logic [IDX_W-1:0]      r_best_idx;
  logic [31:0]           r_best_val;
  logic                  r_neg;
  logic                  r_all_zero;

  logic                  w_accept;
  logic                  w_last;
  logic [31:0]           w_raw_lane0;
  logic [31:0]           w_san_lane0;
  logic [31:0]           w_raw_lane;
  logic [31:0]           w_san_lane;
  logic                  w_greater;

  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last      = (r_scan == LastIdx);

  // Lane 0 seeds the running best directly from the input word on accept.
  assign w_raw_lane0 = i_in_data[31:0];
  assign w_san_lane0 = w_raw_lane0[31] ? 32'h0000_0000 : w_raw_lane0;

  assign w_raw_lane  = r_buf[32*int'(r_scan) +: 32];
  assign w_san_lane  = w_raw_lane[31] ? 32'h0000_0000 : w_raw_lane;

  // Sanitised lanes are non-negative floats, so their unsigned integer order
  // equals their numeric order (+Inf above finite, NaN patterns above +Inf).
  // A strict compare keeps the lowest index on ties.
  assign w_greater   = (w_san_lane > r_best_val);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept)    w_state_next = StScan;
      StScan:  if (w_last)      w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default:                  w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    unique case (r_state)
      StIdle:  o_in_ready  = 1'b1;
      StDone:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: lane buffer, scan counter and running best
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf      <= '0;
      r_scan     <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_neg      <= 1'b0;
      r_all_zero <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_buf      <= i_in_data;
            r_best_val <= w_san_lane0;
            r_best_idx <= '0;
            r_scan     <= IDX_W'(1);
            r_neg      <= w_raw_lane0[31];
            r_all_zero <= (w_san_lane0 == 32'h0000_0000);
          end
        end
        StScan: begin
          if (w_greater) begin
            r_best_val <= w_san_lane;
            r_best_idx <= r_scan;
            // Strictly greater than a non-negative value, so it is non-zero.
            r_all_zero <= 1'b0;
          end
          r_neg  <= r_neg | w_raw_lane[31];
          r_scan <= r_scan + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result fields come straight from registers, so they hold through a stall.
  assign o_out_class    = r_best_idx;
  assign o_out_max      = r_best_val;
  assign o_out_all_zero = r_all_zero;
  assign o_out_neg_seen = r_neg;

endmodule

// File: tb/tb_relu_argmax_classifier.sv
// Directed bench for relu_argmax_classifier: table of vectors with
// hand-computed results, plus backpressure and mid-scan reset sequences.
module tb_relu_argmax_classifier;

  localparam int N = 10;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [32*N-1:0] in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_class;
  logic [31:0]    out_max;
  logic           out_all_zero;
  logic           out_neg_seen;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [32*N-1:0] data;
    logic [W-1:0]    cls;
    logic [31:0]     max;
    logic            az;
    logic            neg;
  } vec_t;

  vec_t vecs [6];

  relu_argmax_classifier #(
    .NUM_IN (N),
    .IDX_W  (W)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_class    (out_class),
    .o_out_max      (out_max),
    .o_out_all_zero (out_all_zero),
    .o_out_neg_seen (out_neg_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present a vector and return just after the edge that accepts it.
  task automatic put(input logic [32*N-1:0] d);
    int waited;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 30);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_valid"},    {31'b0, out_valid},    32'd1);
    chk({tag, "_class"},    {28'b0, out_class},    {28'b0, v.cls});
    chk({tag, "_max"},      out_max,               v.max);
    chk({tag, "_all_zero"}, {31'b0, out_all_zero}, {31'b0, v.az});
    chk({tag, "_neg_seen"}, {31'b0, out_neg_seen}, {31'b0, v.neg});
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_ready_rise"}, {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    int   lat;
    logic stable;
    logic never;

    // Vector table
    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // {0.5, 2.0, 1.0, 0...}
    vecs[0].data[0*32 +: 32] = 32'h3F00_0000;
    vecs[0].data[1*32 +: 32] = 32'h4000_0000;
    vecs[0].data[2*32 +: 32] = 32'h3F80_0000;
    vecs[0].cls = 4'd1; vecs[0].max = 32'h4000_0000; vecs[0].az = 1'b0; vecs[0].neg = 1'b0;
    // Tie between lanes 3 and 7: lowest index wins
    vecs[1].data[3*32 +: 32] = 32'h3F80_0000;
    vecs[1].data[7*32 +: 32] = 32'h3F80_0000;
    vecs[1].cls = 4'd3; vecs[1].max = 32'h3F80_0000; vecs[1].az = 1'b0; vecs[1].neg = 1'b0;
    // Only a -1.0 in lane 5: sanitised to zero
    vecs[2].data[5*32 +: 32] = 32'hBF80_0000;
    vecs[2].cls = 4'd0; vecs[2].max = 32'h0; vecs[2].az = 1'b1; vecs[2].neg = 1'b1;
    // +Inf in the last lane beats max finite in lane 0
    vecs[3].data[0*32 +: 32] = 32'h7F7F_FFFF;
    vecs[3].data[9*32 +: 32] = 32'h7F80_0000;
    vecs[3].cls = 4'd9; vecs[3].max = 32'h7F80_0000; vecs[3].az = 1'b0; vecs[3].neg = 1'b0;
    // NaN pattern beats +Inf
    vecs[4].data[2*32 +: 32] = 32'h7F80_0000;
    vecs[4].data[4*32 +: 32] = 32'h7FC0_0000;
    vecs[4].cls = 4'd4; vecs[4].max = 32'h7FC0_0000; vecs[4].az = 1'b0; vecs[4].neg = 1'b0;
    // Negative NaN in lane 0 is clamped; smallest denormal in lane 8 wins
    vecs[5].data[0*32 +: 32] = 32'hFFC0_0000;
    vecs[5].data[8*32 +: 32] = 32'h0000_0001;
    vecs[5].cls = 4'd8; vecs[5].max = 32'h0000_0001; vecs[5].az = 1'b0; vecs[5].neg = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {31'b0, in_ready},     32'd1);
    chk("rst_out_valid2",{31'b0, out_valid},    32'd0);
    chk("rst_class",     {28'b0, out_class},    32'd0);
    chk("rst_max",       out_max,               32'd0);
    chk("rst_all_zero",  {31'b0, out_all_zero}, 32'd0);
    chk("rst_neg_seen",  {31'b0, out_neg_seen}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      put(vecs[i].data);
      chk($sformatf("v%0d_busy", i), {31'b0, in_ready}, 32'd0);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd9);
      check_result($sformatf("v%0d", i), vecs[i]);
      handshake($sformatf("v%0d", i));
    end

    // Backpressure: hold the result for 20 cycles with a second vector waiting
    put(vecs[0].data);
    wait_done(lat);
    chk("bp_latency", lat, 32'd9);
    @(negedge clk);
    in_data  = vecs[1].data;
    in_valid = 1'b1;
    stable   = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== vecs[0].cls ||
          out_max !== vecs[0].max || out_all_zero !== vecs[0].az ||
          out_neg_seen !== vecs[0].neg) stable = 1'b0;
    end
    chk("bp_stall_stable", {31'b0, stable}, 32'd1);
    check_result("bp_first", vecs[0]);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("bp_ready_rise", {31'b0, in_ready},  32'd1);
    // in_valid still high: the next edge accepts the waiting vector
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    chk("bp_second_latency", lat, 32'd9);
    check_result("bp_second", vecs[1]);
    handshake("bp_second");

    // Reset during scan cycle 4 discards the partial result
    put(vecs[3].data);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid",    {31'b0, out_valid},    32'd0);
    chk("abort_class",    {28'b0, out_class},    32'd0);
    chk("abort_max",      out_max,               32'd0);
    chk("abort_all_zero", {31'b0, out_all_zero}, 32'd0);
    chk("abort_neg_seen", {31'b0, out_neg_seen}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    never = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) never = 1'b0;
    end
    chk("abort_no_valid", {31'b0, never},    32'd1);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    put(vecs[0].data);
    wait_done(lat);
    chk("post_abort_latency", lat, 32'd9);
    check_result("post_abort", vecs[0]);
    handshake("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
